// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcodes, IR field positions, sequencer states, ALU select encoding.
package cpu_isa_pkg;

  localparam int unsigned OP_W     = 5;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ALU_OP_W = 11;

  // IR field MSB positions (fields are OP_W / REG_W bits wide, MSB-first)
  localparam int unsigned IR_OP_MSB = 31;
  localparam int unsigned IR_RA_MSB = 26;
  localparam int unsigned IR_RB_MSB = 22;
  localparam int unsigned IR_RC_MSB = 18;

  localparam logic [OP_W-1:0] OP_ADD  = 5'h03;
  localparam logic [OP_W-1:0] OP_SUB  = 5'h04;
  localparam logic [OP_W-1:0] OP_AND  = 5'h05;
  localparam logic [OP_W-1:0] OP_OR   = 5'h06;
  localparam logic [OP_W-1:0] OP_ROR  = 5'h07;
  localparam logic [OP_W-1:0] OP_ROL  = 5'h08;
  localparam logic [OP_W-1:0] OP_SHR  = 5'h09;
  localparam logic [OP_W-1:0] OP_SHRA = 5'h0A;
  localparam logic [OP_W-1:0] OP_SHL  = 5'h0B;
  localparam logic [OP_W-1:0] OP_NEG  = 5'h11;
  localparam logic [OP_W-1:0] OP_NOT  = 5'h12;

  // Bit positions inside the one-hot alu_op vector
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_AND  = 2;
  localparam int unsigned ALU_OR   = 3;
  localparam int unsigned ALU_SHR  = 4;
  localparam int unsigned ALU_SHRA = 5;
  localparam int unsigned ALU_SHL  = 6;
  localparam int unsigned ALU_ROR  = 7;
  localparam int unsigned ALU_ROL  = 8;
  localparam int unsigned ALU_NEG  = 9;
  localparam int unsigned ALU_NOT  = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6,
    ST_HALT = 3'd7
  } state_e;

  // Opcode to one-hot ALU select; all-zero means the opcode is illegal
  function automatic logic [ALU_OP_W-1:0] alu_decode(input logic [OP_W-1:0] op);
    logic [ALU_OP_W-1:0] oh;
    oh = '0;
    case (op)
      OP_ADD:  oh[ALU_ADD]  = 1'b1;
      OP_SUB:  oh[ALU_SUB]  = 1'b1;
      OP_AND:  oh[ALU_AND]  = 1'b1;
      OP_OR:   oh[ALU_OR]   = 1'b1;
      OP_SHR:  oh[ALU_SHR]  = 1'b1;
      OP_SHRA: oh[ALU_SHRA] = 1'b1;
      OP_SHL:  oh[ALU_SHL]  = 1'b1;
      OP_ROR:  oh[ALU_ROR]  = 1'b1;
      OP_ROL:  oh[ALU_ROL]  = 1'b1;
      OP_NEG:  oh[ALU_NEG]  = 1'b1;
      OP_NOT:  oh[ALU_NOT]  = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Sequencer <-> datapath control bundle. INSTR_COUNT_EN adds the retired-instruction counter.
interface alu_instr_sequencer_if;
  import cpu_isa_pkg::*;

  logic                run;
  logic                mem_ready;
  logic [31:0]         IR;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic                PCout;
  logic                MARin;
  logic                IncPC;
  logic                Zin;
  logic                Zlowout;
  logic                PCin;
  logic                Read;
  logic                MDRin;
  logic                MDRout;
  logic                IRin;
  logic                Yin;
  logic [ALU_OP_W-1:0] alu_op;
  logic                busy;
  logic                halted;
`ifdef INSTR_COUNT_EN
  logic [31:0]         instr_count;
`endif

  // Sequencer side
  modport master (
    input  run, mem_ready, IR,
    output Rin, Rout, PCout, MARin, IncPC, Zin, Zlowout, PCin, Read,
           MDRin, MDRout, IRin, Yin, alu_op, busy, halted
`ifdef INSTR_COUNT_EN
    , output instr_count
`endif
  );

  // Datapath / controller side
  modport slave (
    output run, mem_ready, IR,
    input  Rin, Rout, PCout, MARin, IncPC, Zin, Zlowout, PCin, Read,
           MDRin, MDRout, IRin, Yin, alu_op, busy, halted
`ifdef INSTR_COUNT_EN
    , input instr_count
`endif
  );
endinterface

// File: rtl/reg_select_decoder.sv
// Picks Ra/Rb/Rc from IR and turns it into one-hot register load/drive strobes.
module reg_select_decoder
  import cpu_isa_pkg::*;
(
  input  logic [31:0]         ir,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin_en,
  input  logic                rout_en,
  output logic [NUM_REGS-1:0] rin,
  output logic [NUM_REGS-1:0] rout
);

  logic [REG_W-1:0]    sel;
  logic [NUM_REGS-1:0] onehot;
  logic                unused_ir;

  assign unused_ir = ^{ir[31:27], ir[14:0]};

  // Field select, one-hot expand, gate by strobe enables
  always_comb begin
    sel = '0;
    if (gra)      sel = ir[IR_RA_MSB -: REG_W];
    else if (grb) sel = ir[IR_RB_MSB -: REG_W];
    else if (grc) sel = ir[IR_RC_MSB -: REG_W];
    onehot = NUM_REGS'(1) << sel;
    rin    = rin_en  ? onehot : '0;
    rout   = rout_en ? onehot : '0;
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control-step sequencer for register-register ALU instructions.
// Optional build macro: INSTR_COUNT_EN adds a 32-bit retired-instruction counter.
module alu_instr_sequencer
  import cpu_isa_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
)(
  input  logic                  clock,
  input  logic                  clear,
  alu_instr_sequencer_if.master bus
);

  state_e              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [ALU_OP_W-1:0] alu_dec;
  logic                legal, unary;
  logic                gra, grb, grc, rin_en, rout_en;

  assign alu_dec = alu_decode(bus.IR[IR_OP_MSB -: OP_W]);
  assign legal   = |alu_dec;
  assign unary   = alu_dec[ALU_NEG] | alu_dec[ALU_NOT];

  // State and memory-wait counter registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and wait-counter update
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: if (bus.run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1: begin
        if (bus.mem_ready) begin
          state_d    = ST_T2;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == 4'(MEM_WAIT_MAX)) begin
          state_d = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (!legal)     state_d = ST_HALT;
        else if (unary) state_d = ST_T5;
        else            state_d = ST_T4;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = bus.run ? ST_T0 : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe decode; PCin/Zlowout in T1 wait for mem_ready so PC advances once
  always_comb begin
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.PCin    = 1'b0;
    bus.Read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.alu_op  = '0;
    gra         = 1'b0;
    grb         = 1'b0;
    grc         = 1'b0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    bus.busy    = !(state_q inside {ST_IDLE, ST_HALT});
    bus.halted  = (state_q == ST_HALT);
    case (state_q)
      ST_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      ST_T1: begin
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        bus.Zlowout = bus.mem_ready;
        bus.PCin    = bus.mem_ready;
      end
      ST_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      ST_T3: begin
        if (legal) begin
          grb     = 1'b1;
          rout_en = 1'b1;
          if (unary) begin
            bus.alu_op = alu_dec;
            bus.Zin    = 1'b1;
          end else begin
            bus.Yin = 1'b1;
          end
        end
      end
      ST_T4: begin
        grc        = 1'b1;
        rout_en    = 1'b1;
        bus.alu_op = alu_dec;
        bus.Zin    = 1'b1;
      end
      ST_T5: begin
        bus.Zlowout = 1'b1;
        gra         = 1'b1;
        rin_en      = 1'b1;
      end
      default: ;
    endcase
  end

  reg_select_decoder u_reg_sel (
    .ir      (bus.IR),
    .gra     (gra),
    .grb     (grb),
    .grc     (grc),
    .rin_en  (rin_en),
    .rout_en (rout_en),
    .rin     (bus.Rin),
    .rout    (bus.Rout)
  );

`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count_q, instr_count_d;

  // Count retired instructions (one per T5), wrapping naturally
  always_comb begin
    instr_count_d = instr_count_q;
    if (state_q == ST_T5) instr_count_d = instr_count_q + 32'd1;
  end

  // Counter register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) instr_count_q <= '0;
    else        instr_count_q <= instr_count_d;
  end

  assign bus.instr_count = instr_count_q;
`endif

  bus_exclusive_a: assert property (@(posedge clock) disable iff (!clear)
    $onehot0({bus.Rout, bus.PCout, bus.Zlowout, bus.MDRout}));

  alu_op_onehot_a: assert property (@(posedge clock) disable iff (!clear)
    $onehot0(bus.alu_op));

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed self-checking bench for alu_instr_sequencer.
module tb_alu_instr_sequencer;

  logic clock;
  logic clear;
  int   n_checks;
  int   n_errors;
  int   cyc;

  alu_instr_sequencer_if bus ();

  alu_instr_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  // Single-bit control strobe positions in the packed ctl vector
  localparam logic [10:0] C_PCOUT  = 11'h400;
  localparam logic [10:0] C_MARIN  = 11'h200;
  localparam logic [10:0] C_INCPC  = 11'h100;
  localparam logic [10:0] C_ZIN    = 11'h080;
  localparam logic [10:0] C_ZLOW   = 11'h040;
  localparam logic [10:0] C_PCIN   = 11'h020;
  localparam logic [10:0] C_READ   = 11'h010;
  localparam logic [10:0] C_MDRIN  = 11'h008;
  localparam logic [10:0] C_MDROUT = 11'h004;
  localparam logic [10:0] C_IRIN   = 11'h002;
  localparam logic [10:0] C_YIN    = 11'h001;

  localparam logic [10:0] T0_C  = C_PCOUT | C_MARIN | C_INCPC | C_ZIN;
  localparam logic [10:0] T1_C  = C_ZLOW | C_PCIN | C_READ | C_MDRIN;
  localparam logic [10:0] T1W_C = C_READ | C_MDRIN;
  localparam logic [10:0] T2_C  = C_MDROUT | C_IRIN;

  localparam logic [10:0] A_ADD = 11'h001;
  localparam logic [10:0] A_ROL = 11'h100;
  localparam logic [10:0] A_NOT = 11'h400;

  localparam logic [31:0] IR_ADD_1_2_3 = 32'h18918000;
  localparam logic [31:0] IR_ROL_7_0_4 = 32'h43820000;
  localparam logic [31:0] IR_NOT_2_5   = 32'h91280000;
  localparam logic [31:0] IR_ILLEGAL   = 32'hF8000000;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ctl_now();
    return {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.PCin,
            bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [10:0] ctl, input logic [15:0] rin,
                            input logic [15:0] rout, input logic [10:0] alu,
                            input logic busy, input logic halted);
    #1;
    check_eq({tag, ".ctl"},    32'(ctl_now()),  32'(ctl));
    check_eq({tag, ".rin"},    32'(bus.Rin),    32'(rin));
    check_eq({tag, ".rout"},   32'(bus.Rout),   32'(rout));
    check_eq({tag, ".alu"},    32'(bus.alu_op), 32'(alu));
    check_eq({tag, ".busy"},   32'(bus.busy),   32'(busy));
    check_eq({tag, ".halted"}, 32'(bus.halted), 32'(halted));
  endtask

  // Starts with the DUT in T0 and mem_ready high; returns one edge after T5
  task automatic do_instr(input string tag, input logic [15:0] ra, input logic [15:0] rb,
                          input logic [15:0] rc, input logic [10:0] alu, input bit unary);
    check_outs({tag, ".t0"}, T0_C, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
    tick();
    check_outs({tag, ".t1"}, T1_C, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
    tick();
    check_outs({tag, ".t2"}, T2_C, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
    tick();
    if (unary) begin
      check_outs({tag, ".t3"}, C_ZIN, 16'h0, rb, alu, 1'b1, 1'b0);
    end else begin
      check_outs({tag, ".t3"}, C_YIN, 16'h0, rb, 11'h0, 1'b1, 1'b0);
      tick();
      check_outs({tag, ".t4"}, C_ZIN, 16'h0, rc, alu, 1'b1, 1'b0);
    end
    tick();
    check_outs({tag, ".t5"}, C_ZLOW, ra, 16'h0, 11'h0, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    int t_start;
    int pcin_cnt;
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    clear = 1'b0;
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    bus.IR = '0;

    // Reset state
    #1;
    check_outs("reset", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0);
    #5 clear = 1'b1;

    // Idle with run low, then abort mid-T4 via clear
    tick();
    bus.IR = IR_ADD_1_2_3;
    bus.mem_ready = 1'b1;
    check_outs("idle", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    repeat (4) tick();
    check_outs("abort.t4", C_ZIN, 16'h0, 16'h0008, A_ADD, 1'b1, 1'b0);
    #1 clear = 1'b0;
    check_outs("abort.clr", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0);
    #2 clear = 1'b1;
    repeat (2) tick();
    check_outs("abort.idle", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0);

    // Three back-to-back ADD R1,R2,R3
    bus.run = 1'b1;
    tick();
    t_start = cyc;
    do_instr("add0", 16'h0002, 16'h0004, 16'h0008, A_ADD, 1'b0);
    do_instr("add1", 16'h0002, 16'h0004, 16'h0008, A_ADD, 1'b0);
    bus.run = 1'b0;
    do_instr("add2", 16'h0002, 16'h0004, 16'h0008, A_ADD, 1'b0);
    check_outs("add.idle", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0);
    check_eq("add.cycles", 32'(cyc - t_start), 32'd18);
`ifdef INSTR_COUNT_EN
    check_eq("add.count", bus.instr_count, 32'd3);
`endif

    // ROL R7,R0,R4 with run dropped mid-instruction
    bus.IR = IR_ROL_7_0_4;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    do_instr("rol", 16'h0080, 16'h0001, 16'h0010, A_ROL, 1'b0);
    check_outs("rol.idle", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0);

    // NOT R2,R5: five states, no Yin
    bus.IR = IR_NOT_2_5;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    t_start = cyc;
    do_instr("not", 16'h0004, 16'h0020, 16'h0, A_NOT, 1'b1);
    check_outs("not.idle", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0);
    check_eq("not.cycles", 32'(cyc - t_start), 32'd5);

    // Memory wait of 3 cycles
    bus.IR = IR_ADD_1_2_3;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    pcin_cnt = 0;
    tick();
    t_start = cyc;
    for (int i = 0; i < 3; i++) begin
      check_outs("wait.t1", T1W_C, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
      pcin_cnt += int'(bus.PCin);
      tick();
    end
    bus.mem_ready = 1'b1;
    check_outs("wait.ready", T1_C, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
    pcin_cnt += int'(bus.PCin);
    tick();
    check_outs("wait.t2", T2_C, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
    check_eq("wait.t1len", 32'(cyc - t_start), 32'd4);
    check_eq("wait.pcin", 32'(pcin_cnt), 32'd1);
    repeat (4) tick();
    check_outs("wait.idle", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0);

    // Exactly MEM_WAIT_MAX wait cycles still proceed
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    repeat (15) tick();
    check_outs("edge.t1", T1W_C, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
    bus.mem_ready = 1'b1;
    tick();
    check_outs("edge.t2", T2_C, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
    repeat (4) tick();
    check_outs("edge.idle", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0);

    // One more wait cycle times out to HALT
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    repeat (15) tick();
    check_outs("tmo.t1", T1W_C, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
    tick();
    check_outs("tmo.halt", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b1);
    #1 clear = 1'b0;
    #1 clear = 1'b1;
    check_outs("tmo.clr", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0);

    // Illegal opcode halts after T3 and stays halted with run high
    bus.IR = IR_ILLEGAL;
    bus.mem_ready = 1'b1;
    bus.run = 1'b1;
    tick();
    check_outs("ill.t0", T0_C, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
    tick();
    check_outs("ill.t1", T1_C, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
    tick();
    check_outs("ill.t2", T2_C, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
    tick();
    check_outs("ill.t3", 11'h0, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0);
    tick();
    check_outs("ill.halt", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b1);
    repeat (3) tick();
    check_outs("ill.sticky", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b1);
    bus.run = 1'b0;
    #1 clear = 1'b0;
    #1 clear = 1'b1;
    check_outs("ill.clr", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0);
    tick();
    check_outs("ill.idle", 11'h0, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
